// File: rtl/apb_master_bridge.sv
// APB master bridge: turns one user command into a registered APB SETUP/ACCESS
// transfer. It handles slave wait states with a timeout, decodes out-of-range
// slave indices as immediate errors, and chains commands back-to-back.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             transfer,
  input  logic                             read_write,
  input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
  input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
  input  logic [DATA_WIDTH-1:0]            apb_write_data,
  input  logic [DATA_WIDTH/8-1:0]          apb_write_strb,
  output logic [DATA_WIDTH-1:0]            apb_read_data_out,
  output logic                             pslverr,
  output logic                             done,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr_in
);

  localparam int SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_WIDTH-1:0]    r_wait_cnt;
  logic [CNT_WIDTH-1:0]    w_wait_cnt_next;
  logic                    r_read;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_pslverr;
  logic                    r_done;
  logic                    r_busy;

  logic [ADDR_WIDTH-1:0]   w_req_addr;
  logic [SEL_BITS-1:0]     w_req_idx;
  logic [NUM_SLAVES-1:0]   w_req_sel;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_load;
  logic                    w_complete;
  logic                    w_err;

  assign w_req_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign w_req_idx  = w_req_addr[ADDR_WIDTH-1 -: SEL_BITS];

  // Decode the incoming command's slave index to a one-hot select; indices
  // beyond NUM_SLAVES match no bit, so an all-zero select marks a bad index.
  always_comb begin
    w_req_sel = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_req_sel[i] = (w_req_idx == SEL_BITS'(i));
    end
  end

  // Pick the response of the currently selected slave only; others are masked.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel_ready = w_sel_ready | (pready[i] & r_psel[i]);
      w_sel_err   = w_sel_err | (pslverr_in[i] & r_psel[i]);
      w_sel_rdata = w_sel_rdata | (prdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_psel[i]}});
    end
  end

  // Next-state logic: completion detection, wait counting and command chaining.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = {CNT_WIDTH{1'b0}};
    w_load          = 1'b0;
    w_complete      = 1'b0;
    w_err           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (transfer) begin
          w_load       = 1'b1;
          w_next_state = ST_SETUP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (|r_psel) begin
          w_next_state = ST_ACCESS;
        end else begin
          // No slave decoded: finish right away with an error, skip ACCESS.
          w_complete = 1'b1;
          w_err      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_complete = 1'b1;
          w_err      = w_sel_err;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_complete = 1'b1;
          w_err      = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_complete) begin
      if (transfer) begin
        w_load       = 1'b1;
        w_next_state = ST_SETUP;
      end else begin
        w_next_state = ST_IDLE;
      end
    end else begin
      w_load = w_load;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Registered APB and user-side outputs; a new command is captured on w_load.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_read    <= 1'b0;
      r_paddr   <= {ADDR_WIDTH{1'b0}};
      r_psel    <= {NUM_SLAVES{1'b0}};
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= {DATA_WIDTH{1'b0}};
      r_pstrb   <= {STRB_WIDTH{1'b0}};
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_pslverr <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done    <= w_complete;
      r_pslverr <= w_complete & w_err;
      r_busy    <= (w_next_state != ST_IDLE);
      if (w_complete && r_read) begin
        r_rdata <= w_err ? {DATA_WIDTH{1'b0}} : w_sel_rdata;
      end
      if (w_load) begin
        r_read    <= read_write;
        r_paddr   <= w_req_addr;
        r_psel    <= w_req_sel;
        r_penable <= 1'b0;
        r_pwrite  <= ~read_write;
        r_pwdata  <= apb_write_data;
        r_pstrb   <= read_write ? {STRB_WIDTH{1'b0}} : apb_write_strb;
      end else if (w_next_state == ST_ACCESS) begin
        r_penable <= 1'b1;
      end else if (w_next_state == ST_IDLE) begin
        r_psel    <= {NUM_SLAVES{1'b0}};
        r_penable <= 1'b0;
      end
    end
  end

  assign paddr             = r_paddr;
  assign psel              = r_psel;
  assign penable           = r_penable;
  assign pwrite            = r_pwrite;
  assign pwdata            = r_pwdata;
  assign pstrb             = r_pstrb;
  assign apb_read_data_out = r_rdata;
  assign pslverr           = r_pslverr;
  assign done              = r_done;
  assign busy              = r_busy;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: default 2-slave instance plus a 3-slave instance
// for the out-of-range index case. Expected completions go into a queue when a
// command is issued and are popped when done is seen.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset, transfer, transfer3, read_write;
  logic [8:0]  apb_write_paddr, apb_read_paddr;
  logic [7:0]  apb_write_data;
  logic [0:0]  apb_write_strb;

  logic [7:0]  apb_read_data_out, pwdata;
  logic        pslverr, done, busy, penable, pwrite;
  logic [8:0]  paddr;
  logic [1:0]  psel;
  logic [0:0]  pstrb;
  logic [15:0] prdata;
  logic [1:0]  pready, pslverr_in;

  logic [7:0]  rdata3, pwdata3;
  logic        pslverr3, done3, busy3, penable3, pwrite3;
  logic [8:0]  paddr3;
  logic [2:0]  psel3;
  logic [0:0]  pstrb3;
  logic [23:0] prdata3;
  logic [2:0]  pready3, pslverr_in3;

  typedef struct { logic err; logic [7:0] rdata; } exp_t;
  exp_t sb_q[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;
  int n_en;

  always #5 pclk = ~pclk;

  apb_master_bridge dut (
    .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .apb_write_strb(apb_write_strb),
    .apb_read_data_out(apb_read_data_out), .pslverr(pslverr), .done(done), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr_in(pslverr_in)
  );

  apb_master_bridge #(.NUM_SLAVES(3)) dut3 (
    .pclk(pclk), .preset(preset), .transfer(transfer3), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .apb_write_strb(apb_write_strb),
    .apb_read_data_out(rdata3), .pslverr(pslverr3), .done(done3), .busy(busy3),
    .paddr(paddr3), .psel(psel3), .penable(penable3), .pwrite(pwrite3), .pwdata(pwdata3),
    .pstrb(pstrb3), .prdata(prdata3), .pready(pready3), .pslverr_in(pslverr_in3)
  );

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic test_reset();
    preset = 1'b1; transfer = 1'b0; transfer3 = 1'b0; read_write = 1'b0;
    apb_write_paddr = 9'h000; apb_read_paddr = 9'h000; apb_write_data = 8'h00; apb_write_strb = 1'b0;
    prdata = 16'h0000; pready = 2'b00; pslverr_in = 2'b00;
    prdata3 = 24'h000000; pready3 = 3'b000; pslverr_in3 = 3'b000;
    step(); step();
    n_checks++; if (psel !== 2'b00) begin n_errors++; $display("FAIL rst_psel got=%0h exp=0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_errors++; $display("FAIL rst_penable got=%0h exp=0", penable); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    n_checks++; if (pslverr !== 1'b0) begin n_errors++; $display("FAIL rst_pslverr got=%0h exp=0", pslverr); end
    n_checks++; if ({paddr, pwrite, pwdata, pstrb} !== 19'h00000) begin n_errors++; $display("FAIL rst_apb_bus got=%0h exp=0", {paddr, pwrite, pwdata, pstrb}); end
    n_checks++; if (apb_read_data_out !== 8'h00) begin n_errors++; $display("FAIL rst_rdata got=%0h exp=0", apb_read_data_out); end
    n_checks++; if ({psel3, busy3, done3} !== 5'b00000) begin n_errors++; $display("FAIL rst_dut3 got=%0h exp=0", {psel3, busy3, done3}); end
    preset = 1'b0;
  endtask

  // Single write, zero wait; slave 1's error line must be ignored.
  task automatic test_write();
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h005; apb_read_paddr = 9'h1FF;
    apb_write_data = 8'hA5; apb_write_strb = 1'b1; pready = 2'b11; pslverr_in = 2'b10;
    sb_q.push_back('{err: 1'b0, rdata: 8'h00});
    step(); transfer = 1'b0;
    n_checks++; if (psel !== 2'b01) begin n_errors++; $display("FAIL wr_setup_psel got=%0h exp=1", psel); end
    n_checks++; if (penable !== 1'b0) begin n_errors++; $display("FAIL wr_setup_penable got=%0h exp=0", penable); end
    n_checks++; if ({paddr, pwrite, pwdata, pstrb} !== {9'h005, 1'b1, 8'hA5, 1'b1}) begin n_errors++; $display("FAIL wr_setup_bus got=%0h exp=%0h", {paddr, pwrite, pwdata, pstrb}, {9'h005, 1'b1, 8'hA5, 1'b1}); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL wr_setup_busy got=%0h exp=1", busy); end
    step();
    n_checks++; if ({psel, penable} !== 3'b011) begin n_errors++; $display("FAIL wr_access got=%0h exp=3", {psel, penable}); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL wr_access_done got=%0h exp=0", done); end
    step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL wr_done got=%0h exp=1", done); end
    n_checks++; if ({psel, penable, busy} !== 4'b0000) begin n_errors++; $display("FAIL wr_idle got=%0h exp=0", {psel, penable, busy}); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL wr_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (pslverr !== e.err) begin n_errors++; $display("FAIL wr_pslverr got=%0h exp=%0h", pslverr, e.err); end
      n_checks++; if (apb_read_data_out !== e.rdata) begin n_errors++; $display("FAIL wr_rdata got=%0h exp=%0h", apb_read_data_out, e.rdata); end
    end
    step();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL wr_done_pulse got=%0h exp=0", done); end
  endtask

  // Read from slave 1 with two wait cycles; slave 0 ready/error ignored.
  task automatic test_read_wait();
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h1F0; apb_write_paddr = 9'h005;
    prdata = {8'h3C, 8'hFF}; pready = 2'b01; pslverr_in = 2'b01;
    sb_q.push_back('{err: 1'b0, rdata: 8'h3C});
    step(); transfer = 1'b0;
    n_checks++; if ({psel, penable, pwrite, pstrb} !== 5'b10000) begin n_errors++; $display("FAIL rd_setup got=%0h exp=10", {psel, penable, pwrite, pstrb}); end
    n_checks++; if (paddr !== 9'h1F0) begin n_errors++; $display("FAIL rd_paddr got=%0h exp=1f0", paddr); end
    n_en = 0;
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      if (penable === 1'b1) n_en++;
      pready = (n_en >= 3) ? 2'b11 : 2'b01;
      step();
    end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rd_done_timeout got=%0h exp=1", done); end
    n_checks++; if (n_en !== 3) begin n_errors++; $display("FAIL rd_penable_cycles got=%0d exp=3", n_en); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL rd_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (pslverr !== e.err) begin n_errors++; $display("FAIL rd_pslverr got=%0h exp=%0h", pslverr, e.err); end
      n_checks++; if (apb_read_data_out !== e.rdata) begin n_errors++; $display("FAIL rd_rdata got=%0h exp=%0h", apb_read_data_out, e.rdata); end
    end
    pready = 2'b00; pslverr_in = 2'b00;
    step();
  endtask

  // Read from slave 0 that never answers; slave 1's pready must not end it.
  task automatic test_timeout();
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h0A0;
    prdata = {8'h11, 8'h22}; pready = 2'b10; pslverr_in = 2'b00;
    sb_q.push_back('{err: 1'b1, rdata: 8'h00});
    step(); transfer = 1'b0;
    n_en = 0;
    for (int c = 0; c < 60 && done !== 1'b1; c++) begin
      if (penable === 1'b1) n_en++;
      step();
    end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL to_done got=%0h exp=1", done); end
    n_checks++; if (n_en !== 16) begin n_errors++; $display("FAIL to_wait_cycles got=%0d exp=16", n_en); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL to_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (pslverr !== e.err) begin n_errors++; $display("FAIL to_pslverr got=%0h exp=%0h", pslverr, e.err); end
      n_checks++; if (apb_read_data_out !== e.rdata) begin n_errors++; $display("FAIL to_rdata got=%0h exp=%0h", apb_read_data_out, e.rdata); end
    end
    pready = 2'b00;
    step();
  endtask

  // 3-slave instance: index 3 errors without a bus cycle; index 2 reads normally.
  task automatic test_bad_index();
    transfer3 = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h180; apb_write_data = 8'h99; apb_write_strb = 1'b1;
    sb_q.push_back('{err: 1'b1, rdata: 8'h00});
    step(); transfer3 = 1'b0;
    n_checks++; if ({psel3, penable3} !== 4'b0000) begin n_errors++; $display("FAIL bad_setup_sel got=%0h exp=0", {psel3, penable3}); end
    n_checks++; if ({busy3, done3} !== 2'b10) begin n_errors++; $display("FAIL bad_setup_busy got=%0h exp=2", {busy3, done3}); end
    step();
    n_checks++; if ({done3, busy3, psel3, penable3} !== 6'b100000) begin n_errors++; $display("FAIL bad_done got=%0h exp=20", {done3, busy3, psel3, penable3}); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL bad_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (pslverr3 !== e.err) begin n_errors++; $display("FAIL bad_pslverr got=%0h exp=%0h", pslverr3, e.err); end
      n_checks++; if (rdata3 !== e.rdata) begin n_errors++; $display("FAIL bad_rdata got=%0h exp=%0h", rdata3, e.rdata); end
    end
    transfer3 = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h100;
    prdata3 = {8'h77, 8'h11, 8'h22}; pready3 = 3'b100;
    sb_q.push_back('{err: 1'b0, rdata: 8'h77});
    step(); transfer3 = 1'b0;
    n_checks++; if (psel3 !== 3'b100) begin n_errors++; $display("FAIL s2_psel got=%0h exp=4", psel3); end
    step(); step();
    n_checks++; if (done3 !== 1'b1) begin n_errors++; $display("FAIL s2_done got=%0h exp=1", done3); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL s2_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (pslverr3 !== e.err) begin n_errors++; $display("FAIL s2_pslverr got=%0h exp=%0h", pslverr3, e.err); end
      n_checks++; if (rdata3 !== e.rdata) begin n_errors++; $display("FAIL s2_rdata got=%0h exp=%0h", rdata3, e.rdata); end
    end
    pready3 = 3'b000;
    step();
  endtask

  // Write then read with transfer held high and zero wait states.
  task automatic test_back_to_back();
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h010; apb_read_paddr = 9'h1F0;
    apb_write_data = 8'h5A; apb_write_strb = 1'b1; prdata = {8'hC3, 8'h00}; pready = 2'b11;
    sb_q.push_back('{err: 1'b0, rdata: 8'h00});
    step();
    n_checks++; if ({psel, penable, pwrite} !== 4'b0101) begin n_errors++; $display("FAIL b2b_setup1 got=%0h exp=5", {psel, penable, pwrite}); end
    step();
    read_write = 1'b1;
    sb_q.push_back('{err: 1'b0, rdata: 8'hC3});
    n_checks++; if (penable !== 1'b1) begin n_errors++; $display("FAIL b2b_access1 got=%0h exp=1", penable); end
    step(); transfer = 1'b0;
    n_checks++; if ({done, busy} !== 2'b11) begin n_errors++; $display("FAIL b2b_done1 got=%0h exp=3", {done, busy}); end
    n_checks++; if ({psel, penable, pwrite, paddr} !== {2'b10, 1'b0, 1'b0, 9'h1F0}) begin n_errors++; $display("FAIL b2b_setup2 got=%0h exp=%0h", {psel, penable, pwrite, paddr}, {2'b10, 1'b0, 1'b0, 9'h1F0}); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL b2b_sb1 got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if ({pslverr, apb_read_data_out} !== {e.err, e.rdata}) begin n_errors++; $display("FAIL b2b_resp1 got=%0h exp=%0h", {pslverr, apb_read_data_out}, {e.err, e.rdata}); end
    end
    step();
    n_checks++; if ({done, penable, psel} !== 4'b0110) begin n_errors++; $display("FAIL b2b_access2 got=%0h exp=6", {done, penable, psel}); end
    step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done2 got=%0h exp=1", done); end
    if (sb_q.size() == 0) begin n_checks++; n_errors++; $display("FAIL b2b_sb2 got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if ({pslverr, apb_read_data_out} !== {e.err, e.rdata}) begin n_errors++; $display("FAIL b2b_resp2 got=%0h exp=%0h", {pslverr, apb_read_data_out}, {e.err, e.rdata}); end
    end
    pready = 2'b00;
    step();
  endtask

  // Reset mid-ACCESS, with a simultaneous transfer request that must lose.
  task automatic test_reset_abort();
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h1F0; pready = 2'b00;
    step(); transfer = 1'b0;
    step();
    n_checks++; if (penable !== 1'b1) begin n_errors++; $display("FAIL ab_in_access got=%0h exp=1", penable); end
    preset = 1'b1; transfer = 1'b1;
    step();
    preset = 1'b0; transfer = 1'b0;
    n_checks++; if ({psel, penable, busy, done} !== 5'b00000) begin n_errors++; $display("FAIL ab_after_reset got=%0h exp=0", {psel, penable, busy, done}); end
    n_checks++; if (apb_read_data_out !== 8'h00) begin n_errors++; $display("FAIL ab_rdata got=%0h exp=0", apb_read_data_out); end
    step();
    n_checks++; if ({done, busy, psel} !== 4'b0000) begin n_errors++; $display("FAIL ab_no_done got=%0h exp=0", {done, busy, psel}); end
    n_checks++; if (sb_q.size() !== 0) begin n_errors++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_bad_index();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
